hcp_challenge_expand: RTL and testbench

//  Consumer of the hidden-challenge lists from the verify-side challenge generator: takes packed Lc (4 opened rounds) and Lp (4 party indices).

---
 rtl/hcp_pkg.sv | 57 +++++
 rtl/hcp_list_lookup.sv | 24 ++
 rtl/hcp_challenge_expand.sv | 152 +++++++++++++++
 tb/tb_hcp_challenge_expand.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcp_pkg.sv
// Shared sizing, FSM state type and list helpers for the hidden-challenge expander.
// Helpers unpack one entry of a packed Lc/Lp list and enumerate the (i,j) pairs visited by CHECK.
package hcp_pkg;

  localparam int T         = 4;
  localparam int N_ROUNDS  = 8;
  localparam int N_PARTIES = 16;
  localparam int IDX_W     = 5;
  localparam int LIST_W    = T * IDX_W;
  localparam int K_W       = $clog2(T);
  localparam int NUM_PAIRS = T * (T - 1) / 2;
  localparam int PAIR_W    = $clog2(NUM_PAIRS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_EMIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [K_W-1:0] i;
    logic [K_W-1:0] j;
  } pair_t;

  // Entry 0 occupies the most significant IDX_W bits of the packed list.
  function automatic logic [IDX_W-1:0] list_entry(input logic [LIST_W-1:0] list, input int k);
    return list[LIST_W-1-k*IDX_W -: IDX_W];
  endfunction

  function automatic logic lc_in_range(input logic [IDX_W-1:0] e);
    return e < IDX_W'(N_ROUNDS);
  endfunction

  function automatic logic lp_in_range(input logic [IDX_W-1:0] e);
    return e < IDX_W'(N_PARTIES);
  endfunction

  // Pair number idx maps onto (i,j) with i<j in the order (0,1),(0,2),...,(T-2,T-1).
  function automatic pair_t pair_at(input logic [PAIR_W-1:0] idx);
    pair_t p;
    int    n;
    p = '0;
    n = 0;
    for (int a = 0; a < T; a++) begin
      for (int b = a + 1; b < T; b++) begin
        if (n == int'(idx)) begin
          p.i = K_W'(a);
          p.j = K_W'(b);
        end
        n++;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/hcp_list_lookup.sv
// Combinational search of the latched Lc list for a query round number.
// Reports a hit and the lowest matching slot; out-of-range entries never match.
module hcp_list_lookup
  import hcp_pkg::*;
(
  input  logic [LIST_W-1:0] lc_list,
  input  logic [IDX_W-1:0]  query,
  output logic              hit,
  output logic [K_W-1:0]    hit_k
);

  // Descending scan so the last assignment, the lowest slot, wins.
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    for (int k = T - 1; k >= 0; k--) begin
      if (lc_in_range(list_entry(lc_list, k)) && (list_entry(lc_list, k) == query)) begin
        hit   = 1'b1;
        hit_k = K_W'(k);
      end
    end
  end

endmodule

// File: rtl/hcp_challenge_expand.sv
// Validates the Lc/Lp hidden-challenge lists and expands them into an in-order per-round stream.
// Define HCP_LIST_CHECK_EN to enable the CHECK pass (duplicate/range validation and exp_err).
module hcp_challenge_expand
  import hcp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_start,
  input  logic [LIST_W-1:0] Lc,
  input  logic [LIST_W-1:0] Lp,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [IDX_W-1:0]  rnd_idx,
  output logic              rnd_open,
  output logic [IDX_W-1:0]  rnd_party,
  output logic              exp_end,
  output logic              exp_err
);

  state_t             state_q, state_d;
  logic [LIST_W-1:0]  lc_q, lc_d;
  logic [LIST_W-1:0]  lp_q, lp_d;
  logic [IDX_W-1:0]   round_q, round_d;
  logic [IDX_W-1:0]   query;
  logic               hit;
  logic [K_W-1:0]     hit_k;
  logic               emit;

`ifdef HCP_LIST_CHECK_EN
  logic [PAIR_W-1:0]  pair_q, pair_d;
  logic               err_q, err_d;
  pair_t              cur_pair;
  logic               check_fail;
`endif

  assign emit = (state_q == S_EMIT);

`ifdef HCP_LIST_CHECK_EN
  assign cur_pair = pair_at(pair_q);
  // During CHECK the lookup is asked for Lc[j]; a lowest hit below j means an earlier duplicate.
  assign query = (state_q == S_CHECK) ? list_entry(lc_q, int'(cur_pair.j)) : round_q;
  assign check_fail = (hit && (hit_k != cur_pair.j))
                    || !lc_in_range(list_entry(lc_q, int'(cur_pair.i)))
                    || !lc_in_range(list_entry(lc_q, int'(cur_pair.j)))
                    || !lp_in_range(list_entry(lp_q, int'(cur_pair.i)))
                    || !lp_in_range(list_entry(lp_q, int'(cur_pair.j)));
`else
  assign query = round_q;
`endif

  hcp_list_lookup u_lookup (
    .lc_list (lc_q),
    .query   (query),
    .hit     (hit),
    .hit_k   (hit_k)
  );

  // Next-state logic: dropping exp_start aborts CHECK/EMIT back to IDLE ahead of any transfer.
  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    lp_d    = lp_q;
    round_d = round_q;
`ifdef HCP_LIST_CHECK_EN
    pair_d  = pair_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (exp_start) begin
          lc_d    = Lc;
          lp_d    = Lp;
          round_d = '0;
`ifdef HCP_LIST_CHECK_EN
          pair_d  = '0;
          err_d   = 1'b0;
          state_d = S_CHECK;
`else
          state_d = S_EMIT;
`endif
        end
      end
`ifdef HCP_LIST_CHECK_EN
      S_CHECK: begin
        if (!exp_start) begin
          state_d = S_IDLE;
        end else begin
          err_d = err_q | check_fail;
          if (pair_q == PAIR_W'(NUM_PAIRS - 1)) begin
            state_d = err_d ? S_DONE : S_EMIT;
          end else begin
            pair_d = pair_q + PAIR_W'(1);
          end
        end
      end
`endif
      S_EMIT: begin
        if (!exp_start) begin
          state_d = S_IDLE;
          round_d = '0;
        end else if (rnd_ready) begin
          if (round_q == IDX_W'(N_ROUNDS - 1)) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        if (!exp_start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lc_q    <= '0;
      lp_q    <= '0;
      round_q <= '0;
`ifdef HCP_LIST_CHECK_EN
      pair_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
      lp_q    <= lp_d;
      round_q <= round_d;
`ifdef HCP_LIST_CHECK_EN
      pair_q  <= pair_d;
      err_q   <= err_d;
`endif
    end
  end

  assign rnd_valid = emit;
  assign rnd_idx   = emit ? round_q : '0;
  assign rnd_open  = emit & hit;
  assign rnd_party = (emit && hit) ? list_entry(lp_q, int'(hit_k)) : '0;
  assign exp_end   = (state_q == S_DONE);

`ifdef HCP_LIST_CHECK_EN
  assign exp_err = (state_q == S_DONE) & err_q;
`else
  assign exp_err = 1'b0;
`endif

endmodule

// File: tb/tb_hcp_challenge_expand.sv
// Scoreboard bench for hcp_challenge_expand: expected round records are queued from a list model
// at start and popped on every accepted transfer; expectations follow HCP_LIST_CHECK_EN when defined.
module tb_hcp_challenge_expand;

`ifdef HCP_LIST_CHECK_EN
  localparam bit CHK       = 1'b1;
  localparam int FIRST_LAT = 7;
`else
  localparam bit CHK       = 1'b0;
  localparam int FIRST_LAT = 1;
`endif
  localparam int BUDGET = 60;

  typedef struct packed {
    logic [4:0] idx;
    logic       open;
    logic [4:0] party;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exp_start = 1'b0;
  logic        rnd_ready = 1'b0;
  logic [19:0] lc_in = '0;
  logic [19:0] lp_in = '0;
  logic        rnd_valid;
  logic [4:0]  rnd_idx;
  logic        rnd_open;
  logic [4:0]  rnd_party;
  logic        exp_end;
  logic        exp_err;

  int   vectors = 0;
  int   miscompares = 0;
  rec_t exp_q[$];

  hcp_challenge_expand dut (
    .clk       (clk),
    .reset     (reset),
    .exp_start (exp_start),
    .Lc        (lc_in),
    .Lp        (lp_in),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_idx   (rnd_idx),
    .rnd_open  (rnd_open),
    .rnd_party (rnd_party),
    .exp_end   (exp_end),
    .exp_err   (exp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
    return {5'(a), 5'(b), 5'(c), 5'(d)};
  endfunction

  function automatic logic [4:0] ent(input logic [19:0] v, input int k);
    return v[19-5*k -: 5];
  endfunction

  // Lists are bad if any Lc >= 8, any Lp >= 16, or two Lc entries repeat.
  function automatic bit lists_bad(input logic [19:0] lcv, input logic [19:0] lpv);
    bit bad;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ent(lcv, k) >= 5'd8 || ent(lpv, k) >= 5'd16) bad = 1'b1;
      for (int m = k + 1; m < 4; m++) begin
        if (ent(lcv, k) == ent(lcv, m)) bad = 1'b1;
      end
    end
    return bad;
  endfunction

  task automatic push_expected(input logic [19:0] lcv, input logic [19:0] lpv);
    rec_t r;
    exp_q.delete();
    for (int rd = 0; rd < 8; rd++) begin
      r.idx   = 5'(rd);
      r.open  = 1'b0;
      r.party = 5'd0;
      for (int k = 3; k >= 0; k--) begin
        if (ent(lcv, k) == 5'(rd)) begin
          r.open  = 1'b1;
          r.party = ent(lpv, k);
        end
      end
      exp_q.push_back(r);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #4;
    vectors++;
    if ({rnd_valid, rnd_idx, rnd_open, rnd_party, exp_end, exp_err} !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got valid=%b idx=%0d open=%b party=%0d end=%b err=%b expected all 0",
               rnd_valid, rnd_idx, rnd_open, rnd_party, exp_end, exp_err);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [19:0] lcv, lpv;
    rec_t e;
    int   recs, first, last;
    bit   done;
    lcv = pack4(3, 0, 7, 5);
    lpv = pack4(9, 2, 15, 0);
    push_expected(lcv, lpv);
    @(negedge clk);
    lc_in = lcv; lp_in = lpv; rnd_ready = 1'b1; exp_start = 1'b1;
    recs = 0; first = -1; last = -1; done = 1'b0;
    for (int n = 1; n <= BUDGET && !done; n++) begin
      @(negedge clk);
      if (n == 2) begin
        lc_in = '1;
        lp_in = '1;
      end
      if (rnd_valid) begin
        if (first < 0) first = n;
        last = n;
        recs++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL b2b_extra_record got idx=%0d expected no record", rnd_idx);
        end else begin
          e = exp_q.pop_front();
          if ({rnd_idx, rnd_open, rnd_party} !== e) begin
            miscompares++;
            $display("[TB] FAIL b2b_record got idx=%0d open=%b party=%0d expected idx=%0d open=%b party=%0d",
                     rnd_idx, rnd_open, rnd_party, e.idx, e.open, e.party);
          end
        end
      end
      if (exp_end) done = 1'b1;
    end
    vectors++;
    if (first !== FIRST_LAT) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_latency got %0d expected %0d", first, FIRST_LAT);
    end
    vectors++;
    if (recs !== 8 || (last - first) !== 7) begin
      miscompares++;
      $display("[TB] FAIL b2b_count got %0d records over span %0d expected 8 over span 7", recs, last - first);
    end
    vectors++;
    if (!done || exp_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_end got end_seen=%b err=%b expected 1/0", done, exp_err);
    end
    exp_start = 1'b0;
    @(negedge clk);
    vectors++;
    if (exp_end !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_end_clear got exp_end=%b expected 0", exp_end);
    end
  endtask

  task automatic test_stall();
    logic [19:0] lcv, lpv;
    rec_t e, held;
    bit   have_held, done;
    int   valid_cycles, recs;
    lcv = pack4(3, 0, 7, 5);
    lpv = pack4(9, 2, 15, 0);
    push_expected(lcv, lpv);
    @(negedge clk);
    lc_in = lcv; lp_in = lpv; rnd_ready = 1'b1; exp_start = 1'b1;
    have_held = 1'b0; done = 1'b0; valid_cycles = 0; recs = 0; held = '0;
    for (int n = 1; n <= BUDGET && !done; n++) begin
      @(negedge clk);
      rnd_ready = ((n + FIRST_LAT) % 2) == 1;
      if (rnd_valid) begin
        valid_cycles++;
        if (have_held) begin
          vectors++;
          if ({rnd_idx, rnd_open, rnd_party} !== held) begin
            miscompares++;
            $display("[TB] FAIL stall_stable got idx=%0d open=%b party=%0d expected idx=%0d open=%b party=%0d",
                     rnd_idx, rnd_open, rnd_party, held.idx, held.open, held.party);
          end
          have_held = 1'b0;
        end
        if (rnd_ready) begin
          recs++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL stall_extra_record got idx=%0d expected no record", rnd_idx);
          end else begin
            e = exp_q.pop_front();
            if ({rnd_idx, rnd_open, rnd_party} !== e) begin
              miscompares++;
              $display("[TB] FAIL stall_record got idx=%0d open=%b party=%0d expected idx=%0d open=%b party=%0d",
                       rnd_idx, rnd_open, rnd_party, e.idx, e.open, e.party);
            end
          end
        end else begin
          held = {rnd_idx, rnd_open, rnd_party};
          have_held = 1'b1;
        end
      end
      if (exp_end) done = 1'b1;
    end
    vectors++;
    if (valid_cycles !== 16 || recs !== 8 || !done) begin
      miscompares++;
      $display("[TB] FAIL stall_emit_cycles got %0d cycles %0d records end=%b expected 16 cycles 8 records end=1",
               valid_cycles, recs, done);
    end
    rnd_ready = 1'b1;
    exp_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_list_errors();
    logic [19:0] c_lc[4], c_lp[4];
    logic [19:0] lcv, lpv;
    rec_t e;
    bit   err_exp, done;
    int   recs, recs_exp;
    c_lc[0] = pack4(1, 1, 2, 3); c_lp[0] = pack4(9, 2, 15, 0);
    c_lc[1] = pack4(0, 8, 2, 3); c_lp[1] = pack4(9, 2, 15, 0);
    c_lc[2] = pack4(3, 0, 7, 5); c_lp[2] = pack4(0, 16, 1, 1);
    c_lc[3] = pack4(3, 0, 7, 5); c_lp[3] = pack4(4, 4, 4, 4);
    for (int c = 0; c < 4; c++) begin
      lcv = c_lc[c];
      lpv = c_lp[c];
      err_exp = CHK && lists_bad(lcv, lpv);
      push_expected(lcv, lpv);
      if (err_exp) exp_q.delete();
      recs_exp = exp_q.size();
      @(negedge clk);
      lc_in = lcv; lp_in = lpv; rnd_ready = 1'b1; exp_start = 1'b1;
      recs = 0; done = 1'b0;
      for (int n = 1; n <= BUDGET && !done; n++) begin
        @(negedge clk);
        if (rnd_valid) begin
          recs++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL err_case%0d_extra_record got idx=%0d expected no record", c, rnd_idx);
          end else begin
            e = exp_q.pop_front();
            if ({rnd_idx, rnd_open, rnd_party} !== e) begin
              miscompares++;
              $display("[TB] FAIL err_case%0d_record got idx=%0d open=%b party=%0d expected idx=%0d open=%b party=%0d",
                       c, rnd_idx, rnd_open, rnd_party, e.idx, e.open, e.party);
            end
          end
        end
        if (exp_end) done = 1'b1;
      end
      vectors++;
      if (!done || exp_err !== err_exp || recs !== recs_exp) begin
        miscompares++;
        $display("[TB] FAIL err_case%0d got end=%b err=%b records=%0d expected end=1 err=%b records=%0d",
                 c, done, exp_err, recs, err_exp, recs_exp);
      end
      exp_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    logic [19:0] lcv, lpv;
    rec_t e;
    bit   dropped;
    int   after;
    lcv = pack4(6, 1, 4, 2);
    lpv = pack4(11, 3, 7, 14);
    push_expected(lcv, lpv);
    @(negedge clk);
    lc_in = lcv; lp_in = lpv; rnd_ready = 1'b1; exp_start = 1'b1;
    dropped = 1'b0; after = 0;
    for (int n = 1; n <= BUDGET && after < 4; n++) begin
      @(negedge clk);
      if (dropped) begin
        after++;
        vectors++;
        if (rnd_valid !== 1'b0 || exp_end !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL abort_idle got valid=%b end=%b expected 0/0", rnd_valid, exp_end);
        end
      end else if (rnd_valid) begin
        vectors++;
        e = exp_q.pop_front();
        if ({rnd_idx, rnd_open, rnd_party} !== e) begin
          miscompares++;
          $display("[TB] FAIL abort_record got idx=%0d open=%b party=%0d expected idx=%0d open=%b party=%0d",
                   rnd_idx, rnd_open, rnd_party, e.idx, e.open, e.party);
        end
        if (e.idx == 5'd4) begin
          exp_start = 1'b0;
          dropped = 1'b1;
        end
      end
    end
    vectors++;
    if (after !== 4) begin
      miscompares++;
      $display("[TB] FAIL abort_timeout got %0d idle cycles expected 4", after);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_in_emit();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    lc_in = pack4(3, 0, 7, 5); lp_in = pack4(9, 2, 15, 0); rnd_ready = 1'b0; exp_start = 1'b1;
    for (int n = 1; n <= BUDGET && !seen; n++) begin
      @(negedge clk);
      if (rnd_valid) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL rst_emit_reach got valid=0 expected EMIT within %0d cycles", BUDGET);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({rnd_valid, rnd_idx, rnd_open, rnd_party, exp_end, exp_err} !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_emit_outputs got valid=%b idx=%0d open=%b party=%0d end=%b err=%b expected all 0",
               rnd_valid, rnd_idx, rnd_open, rnd_party, exp_end, exp_err);
    end
    exp_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rnd_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_done_hold();
    logic [19:0] lcv, lpv;
    rec_t e;
    bit   done;
    lcv = pack4(7, 6, 5, 4);
    lpv = pack4(1, 0, 13, 8);
    push_expected(lcv, lpv);
    @(negedge clk);
    lc_in = lcv; lp_in = lpv; rnd_ready = 1'b1; exp_start = 1'b1;
    done = 1'b0;
    for (int n = 1; n <= BUDGET && !done; n++) begin
      @(negedge clk);
      if (rnd_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL hold_extra_record got idx=%0d expected no record", rnd_idx);
        end else begin
          e = exp_q.pop_front();
          if ({rnd_idx, rnd_open, rnd_party} !== e) begin
            miscompares++;
            $display("[TB] FAIL hold_record got idx=%0d open=%b party=%0d expected idx=%0d open=%b party=%0d",
                     rnd_idx, rnd_open, rnd_party, e.idx, e.open, e.party);
          end
        end
      end
      if (exp_end) done = 1'b1;
    end
    vectors++;
    if (!done || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL hold_run got end=%b pending=%0d expected end=1 pending=0", done, exp_q.size());
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      vectors++;
      if (exp_end !== 1'b1 || rnd_valid !== 1'b0 || exp_err !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_done got end=%b valid=%b err=%b expected 1/0/0", exp_end, rnd_valid, exp_err);
      end
    end
    exp_start = 1'b0;
    @(negedge clk);
    vectors++;
    if (exp_end !== 1'b0 || exp_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_release got end=%b err=%b expected 0/0", exp_end, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_list_errors();
    test_abort();
    test_back_to_back();
    test_reset_in_emit();
    test_done_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
